// File: rtl/link_pkg.sv
// Shared definitions for the game-state link: start-of-frame default, framer FSM states, byte sizing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package link_pkg;

  localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_SEQ,
    ST_PAYLOAD,
    ST_CHK
  } state_t;

  // Whole bytes needed to carry one field.
  function automatic int bytes_per_field(input int field_w);
    return (field_w + 7) / 8;
  endfunction

  // Index width able to address n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/link_byte_sel.sv
// Selects one payload byte from the shadow field vector; each field is little-endian and zero-padded to whole bytes.
// Latency: combinational.
// Backpressure: none, pure lookup.
module link_byte_sel
  import link_pkg::*;
#(
  parameter int NUM_FIELDS = 8,
  parameter int FIELD_W    = 10,
  localparam int BPF       = bytes_per_field(FIELD_W),
  localparam int NB        = NUM_FIELDS * BPF,
  localparam int IDX_W     = idx_width(NB)
) (
  input  logic [NUM_FIELDS*FIELD_W-1:0] i_shadow,
  input  logic [IDX_W-1:0]              i_idx,
  output logic [7:0]                    o_byte
);

  logic [NB*8-1:0] w_padded;

  // Spread each field onto its own byte-aligned slot, upper pad bits stay zero
  always_comb begin
    w_padded = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      w_padded[i*BPF*8 +: FIELD_W] = i_shadow[i*FIELD_W +: FIELD_W];
    end
  end

  // Pick the addressed byte; an index past the payload reads as zero
  always_comb begin
    o_byte = '0;
    for (int b = 0; b < NB; b++) begin
      if (i_idx == IDX_W'(b)) begin
        o_byte = w_padded[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/uart_frame_packer.sv
// Frames a snapshot of NUM_FIELDS game fields as SOF, SEQ, payload, XOR checksum onto the UART tx byte port.
// Latency: SOF presented one cycle after send; one byte per cycle while tx_ready is high, no bubbles.
// Backpressure: tx_valid/tx_data hold until tx_ready; one extra request is queued, further ones pulse dropped.
module uart_frame_packer
  import link_pkg::*;
#(
  parameter int         NUM_FIELDS = 8,
  parameter int         FIELD_W    = 10,
  parameter logic [7:0] SOF_BYTE   = SOF_BYTE_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_FIELDS*FIELD_W-1:0] fields_in,
  input  logic                          send,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          dropped,
  output logic [7:0]                    seq_out
);

  localparam int              BPF      = bytes_per_field(FIELD_W);
  localparam int              NB       = NUM_FIELDS * BPF;
  localparam int              IDX_W    = idx_width(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  state_t                        r_state;
  logic [NUM_FIELDS*FIELD_W-1:0] r_shadow;
  logic [IDX_W-1:0]              r_idx;
  logic [7:0]                    r_chk;
  logic [7:0]                    r_seq;
  logic                          r_pending;
  logic [7:0]                    r_tx_data;
  logic                          r_tx_valid;
  logic                          r_busy;
  logic                          r_dropped;

  logic                          w_fire;
  logic [IDX_W-1:0]              w_sel_idx;
  logic [7:0]                    w_pay_byte;

  assign w_fire = r_tx_valid & tx_ready;

  // Look ahead to the byte that follows the one currently on the bus
  always_comb begin
    w_sel_idx = '0;
    if (r_state == ST_PAYLOAD) begin
      w_sel_idx = r_idx + IDX_W'(1);
    end
  end

  link_byte_sel #(
    .NUM_FIELDS (NUM_FIELDS),
    .FIELD_W    (FIELD_W)
  ) u_byte_sel (
    .i_shadow (r_shadow),
    .i_idx    (w_sel_idx),
    .o_byte   (w_pay_byte)
  );

  // Framer FSM: state names the byte being offered; every step waits for a handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_shadow   <= '0;
      r_idx      <= '0;
      r_chk      <= '0;
      r_seq      <= '0;
      r_pending  <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_dropped <= 1'b0;
      // A request during a frame is remembered once; anything beyond that is discarded
      if (send && r_busy) begin
        if (r_pending) begin
          r_dropped <= 1'b1;
        end else begin
          r_pending <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (send) begin
            r_shadow   <= fields_in;
            r_tx_data  <= SOF_BYTE;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_SOF;
          end
        end
        ST_SOF: begin
          if (w_fire) begin
            r_tx_data <= r_seq;
            r_state   <= ST_SEQ;
          end
        end
        ST_SEQ: begin
          if (w_fire) begin
            r_chk     <= r_tx_data;
            r_tx_data <= w_pay_byte;
            r_idx     <= '0;
            r_state   <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (w_fire) begin
            if (r_idx == LAST_IDX) begin
              r_tx_data <= r_chk ^ r_tx_data;
              r_state   <= ST_CHK;
            end else begin
              r_chk     <= r_chk ^ r_tx_data;
              r_tx_data <= w_pay_byte;
              r_idx     <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_CHK: begin
          if (w_fire) begin
            r_seq     <= r_seq + 8'd1;
            r_pending <= 1'b0;
            if (r_pending || send) begin
              // Back-to-back frame: fresh snapshot taken now, valid never drops
              r_shadow  <= fields_in;
              r_tx_data <= SOF_BYTE;
              r_state   <= ST_SOF;
            end else begin
              r_tx_data  <= '0;
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign dropped  = r_dropped;
  assign seq_out  = r_seq;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Scoreboard bench for uart_frame_packer with two 10-bit fields.
// Latency: n/a.
// Backpressure: tx_ready driven by the bench.
module tb_uart_frame_packer;

  localparam int         NF  = 2;
  localparam int         FW  = 10;
  localparam logic [19:0] F_A = {10'h3FF, 10'h155};
  localparam logic [19:0] F_B = {10'h001, 10'h000};

  logic          clk = 1'b0;
  logic          rst;
  logic [NF*FW-1:0] fields_in;
  logic          send;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          dropped;
  logic [7:0]    seq_out;

  logic [7:0]    exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_acc    = 0;

  uart_frame_packer #(
    .NUM_FIELDS (NF),
    .FIELD_W    (FW),
    .SOF_BYTE   (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fields_in (fields_in),
    .send      (send),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .dropped   (dropped),
    .seq_out   (seq_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame builder: SOF, SEQ, little-endian padded fields, XOR of SEQ and payload.
  task automatic push_frame(input logic [NF*FW-1:0] flds, input logic [7:0] seq);
    logic [7:0]  c;
    logic [15:0] p;
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    c = seq;
    for (int i = 0; i < NF; i++) begin
      p = {6'd0, flds[i*FW +: FW]};
      for (int j = 0; j < 2; j++) begin
        exp_q.push_back(p[j*8 +: 8]);
        c = c ^ p[j*8 +: 8];
      end
    end
    exp_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_send();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (n_acc < n && t < 2000);
    if (n_acc < n) check_eq("wait_acc_timeout", 32'(n_acc), 32'(n));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (!(exp_q.size() == 0 && !busy) && t < 5000);
    check_eq("frame_done_busy", 32'(busy), 32'd0);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Every accepted byte must be the next one the scoreboard expects
  always @(negedge clk) begin
    if (rst && tx_valid && tx_ready) begin
      n_acc++;
      if (exp_q.size() == 0) check_eq("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
      else check_eq("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0]  t1 [7];
    logic [19:0] f;
    logic [7:0]  seq;
    int          base;
    int          nfr;
    int          start;

    rst       = 1'b0;
    send      = 1'b0;
    tx_ready  = 1'b1;
    fields_in = '0;
    repeat (3) tick();
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data",  32'(tx_data),  32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    check_eq("rst_dropped",  32'(dropped),  32'd0);
    check_eq("rst_seq",      32'(seq_out),  32'd0);
    rst = 1'b1;
    tick();

    // Frame 0: known byte stream, no stalls
    t1 = '{8'hA5, 8'h00, 8'h55, 8'h01, 8'hFF, 8'h03, 8'hA8};
    foreach (t1[i]) exp_q.push_back(t1[i]);
    fields_in = F_A;
    pulse_send();
    check_eq("t1_busy_with_valid", 32'(busy), 32'd1);
    for (int k = 0; k < 7; k++) begin
      check_eq("t1_valid_run", 32'(tx_valid), 32'd1);
      tick();
    end
    check_eq("t1_busy_fall",  32'(busy),     32'd0);
    check_eq("t1_valid_fall", 32'(tx_valid), 32'd0);
    check_eq("t1_count",      32'(n_acc),    32'd7);
    check_eq("t1_seq",        32'(seq_out),  32'd1);
    check_eq("sb_after_t1",   32'(exp_q.size()), 32'd0);

    // Frame 1: stall five cycles on the payload byte 0x01
    push_frame(F_A, 8'd1);
    base = n_acc;
    pulse_send();
    wait_acc(base + 3);
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_eq("t2_hold_valid", 32'(tx_valid), 32'd1);
      check_eq("t2_hold_data",  32'(tx_data),  32'h01);
      tick();
    end
    check_eq("t2_no_accept", 32'(n_acc - base), 32'd3);
    tx_ready = 1'b1;
    wait_done();
    check_eq("t2_count", 32'(n_acc - base), 32'd7);

    // Frames 2,3: request queued mid-frame, new fields must not leak into frame 2
    push_frame(F_A, 8'd2);
    pulse_send();
    tick();
    tick();
    fields_in = F_B;
    push_frame(F_B, 8'd3);
    pulse_send();
    for (int k = 0; k < 11; k++) begin
      check_eq("t3_back2back_valid", 32'(tx_valid), 32'd1);
      tick();
    end
    check_eq("t3_busy_fall", 32'(busy),    32'd0);
    check_eq("t3_seq",       32'(seq_out), 32'd4);
    check_eq("sb_after_t3",  32'(exp_q.size()), 32'd0);

    // Frames 4,5: third request while one is already queued gets dropped
    fields_in = F_A;
    base = n_acc;
    push_frame(F_A, 8'd4);
    pulse_send();
    tick();
    push_frame(F_A, 8'd5);
    pulse_send();
    check_eq("t4_no_drop_first", 32'(dropped), 32'd0);
    pulse_send();
    check_eq("t4_drop_pulse", 32'(dropped), 32'd1);
    tick();
    check_eq("t4_drop_one_cycle", 32'(dropped), 32'd0);
    wait_done();
    check_eq("t4_two_frames", 32'(n_acc - base), 32'd14);
    check_eq("t4_seq",        32'(seq_out),      32'd6);

    // Back-to-back random frames through the sequence wrap
    nfr   = 256 - 6 + 1;
    seq   = 8'd6;
    start = n_acc;
    f = 20'($urandom);
    fields_in = f;
    push_frame(f, seq);
    pulse_send();
    for (int k = 1; k < nfr; k++) begin
      wait_acc(start + 2);
      start = start + 7;
      seq   = seq + 8'd1;
      f = 20'($urandom);
      fields_in = f;
      push_frame(f, seq);
      pulse_send();
    end
    wait_done();
    check_eq("t5_last_seq_sent", 32'(seq), 32'd0);
    check_eq("t5_seq_wrapped",   32'(seq_out), 32'd1);

    // Asynchronous reset in the middle of the payload
    fields_in = F_A;
    base = n_acc;
    push_frame(F_A, 8'd1);
    pulse_send();
    wait_acc(base + 3);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(tx_valid), 32'd0);
    check_eq("t6_rst_busy",  32'(busy),     32'd0);
    check_eq("t6_rst_seq",   32'(seq_out),  32'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
    fields_in = F_B;
    push_frame(F_B, 8'd0);
    pulse_send();
    wait_done();
    check_eq("t6_seq_after", 32'(seq_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
